muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The module SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-003 The module SHALL have port start, input, 1 bit, an EX-stage M-extension operation is present (opcode OP, funct7=0000001).
REQ-004 The module SHALL have port funct3, input, 3 bits, operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 The module SHALL have port a, input, 32 bits, bypassed rs1 operand (ALU Ain).
REQ-006 The module SHALL have port b, input, 32 bits, bypassed rs2 operand (ALU Bin).
REQ-007 The module SHALL have port rd_in, input, 5 bits, destination register of the operation.
REQ-008 The module SHALL have port kill, input, 1 bit, flush of the EX stage.
REQ-009 The module SHALL have port stall, output, 1 bit, holds IF/ID/EX pipeline registers.
REQ-010 The module SHALL have port busy, output, 1 bit, state is not IDLE.
REQ-011 The module SHALL have port done, output, 1 bit, result valid this cycle.
REQ-012 The module SHALL have port result, output, 32 bits, operation result, valid only while done=1.
REQ-013 The module SHALL have port rd_out, output, 5 bits, captured rd_in, valid while done=1.
REQ-014 The module SHALL have parameter ITER, default 32, the number of RUN cycles, one operand bit per cycle.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE, with register-based state.
REQ-016 In IDLE, when start=1 and kill=0 at a rising edge, the module SHALL capture funct3, rd_in and operand magnitudes and result sign, clear the iteration counter, and go to RUN; on the fast path it SHALL go directly to DONE.
REQ-017 The fast path SHALL apply to:
  - divide-by-zero (b=0): DIV/DIVU result 0xFFFFFFFF; REM/REMU result = a.
  - signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV result 0x80000000; REM result 0.
REQ-018 RUN SHALL perform one shift-add multiply step or one restoring-divide step per cycle on a 64-bit accumulator, and go to DONE after exactly ITER RUN cycles.
REQ-019 Sign handling SHALL be:
  - Signed operands: MULH both, MULHSU a only, DIV/REM both.
  - Operands are converted to magnitudes before RUN.
  - Product and quotient are negated when the operand signs differ.
  - Remainder takes the sign of a.
REQ-020 Result selection SHALL be: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-021 DONE SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-022 Latency: with start high in cycle N, done SHALL be high in cycle N+ITER+1 on the normal path and in cycle N+1 on the fast path.
REQ-023 stall SHALL be the combinational value (state==IDLE and start and not kill) or state==RUN.
REQ-024 stall SHALL be 0 in DONE so the pipeline advances and captures result.
REQ-025 start while in RUN or DONE SHALL be ignored; the held instruction is not re-issued.
REQ-026 start in the same cycle as done SHALL NOT begin a new operation; a new operation requires IDLE.
REQ-027 When kill=1 at a rising edge in any state, the module SHALL go to IDLE next cycle without asserting done.
REQ-028 kill SHALL have priority over start and over RUN completion.
REQ-029 Counter and accumulator widths SHALL be: counter $clog2(ITER)+1 bits; no arithmetic overflow beyond 64 bits.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE; stall=0, busy=0, done=0, result=0, rd_out=0; counter and accumulators cleared.
REQ-031 Reset deassertion mid-operation SHALL leave the module in IDLE; the aborted operation never signals done.

Verification
REQ-032 The bench SHALL cover: MUL a=7, b=6, rd=5 -> stall 1 cycles N..N+32; done at N+33; result=42; rd_out=5.
REQ-033 The bench SHALL cover: MULH a=0x80000000, b=0x80000000 -> result 0x40000000; MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE.
REQ-034 The bench SHALL cover: DIV a=-7, b=2 -> result 0xFFFFFFFD; REM same operands -> result 0xFFFFFFFF; DIVU a=100, b=7 -> result 14.
REQ-035 The bench SHALL cover: DIVU b=0 -> done at N+1, result 0xFFFFFFFF; REM a=0x80000000, b=-1 -> done at N+1, result 0.
REQ-036 The bench SHALL cover: kill at cycle N+10 of a DIV -> IDLE at N+11; no done; stall=0; next start executes normally.
REQ-037 The bench SHALL cover: reset pulled low at N+5 -> immediate outputs 0; after release, start a MUL, verify done at the correct latency and value.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_sequencer #(
  parameter int unsigned ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd_in,
  input  logic        kill,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam int unsigned CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   acc;
  logic [31:0]   opb;
  logic [2:0]    op;
  logic          neg_res;

  logic          sgn_a, sgn_b, neg_a, neg_b, is_div, div_zero, ovf, fast;
  logic [31:0]   mag_a, mag_b, fast_val;
  logic [63:0]   acc_next, prod;
  logic [32:0]   mul_sum, rem_sh, rem_diff;
  logic          rem_ge;
  logic [31:0]   quo, rem, res_c;

  // Operand decode: signedness, magnitudes and the fast-path cases.
  always_comb begin
    is_div   = funct3[2];
    sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a    = sgn_a & a[31];
    neg_b    = sgn_b & b[31];
    mag_a    = neg_a ? (32'd0 - a) : a;
    mag_b    = neg_b ? (32'd0 - b) : b;
    div_zero = is_div && (b == 32'd0);
    ovf      = is_div && !funct3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    fast     = div_zero || ovf;
    fast_val = 32'd0;
    if (div_zero) fast_val = funct3[1] ? a : 32'hFFFF_FFFF;
    else          fast_val = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration: acc = {hi, lo}; multiply shifts right, divide shifts left.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    rem_sh   = acc[63:31];
    rem_ge   = rem_sh >= {1'b0, opb};
    rem_diff = rem_sh - {1'b0, opb};
    acc_next = acc;
    if (op[2]) acc_next = {(rem_ge ? rem_diff[31:0] : rem_sh[31:0]), acc[30:0], rem_ge};
    else       acc_next = {mul_sum, acc[31:1]};
  end

  // Sign fix-up and result selection from the final accumulator.
  always_comb begin
    prod = neg_res ? (64'd0 - acc_next) : acc_next;
    quo  = neg_res ? (32'd0 - acc_next[31:0]) : acc_next[31:0];
    rem  = neg_res ? (32'd0 - acc_next[63:32]) : acc_next[63:32];
    case (op)
      3'b000:                 res_c = prod[31:0];
      3'b001, 3'b010, 3'b011: res_c = prod[63:32];
      3'b100, 3'b101:         res_c = quo;
      default:                res_c = rem;
    endcase
  end

  // Gated by reset so the pipeline never sees a stall while held in reset.
  assign stall = reset & (((state == IDLE) & start & ~kill) | (state == RUN));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'd0;
      rd_out  <= 5'd0;
      cnt     <= '0;
      acc     <= 64'd0;
      opb     <= 32'd0;
      op      <= 3'd0;
      neg_res <= 1'b0;
    end else if (kill) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op      <= funct3;
            rd_out  <= rd_in;
            cnt     <= '0;
            opb     <= mag_b;
            acc     <= {32'd0, mag_a};
            neg_res <= (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);
            busy    <= 1'b1;
            if (fast) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= fast_val;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= res_c;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, kill/reset
// corner sequences and random operations against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int ITER = 32;

  logic        clock, reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.ITER(ITER)) dut (
    .clock(clock), .reset(reset), .start(start), .funct3(funct3),
    .a(a), .b(b), .rd_in(rd_in), .kill(kill),
    .stall(stall), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] av;
    logic [31:0] bv;
    logic [4:0]  rd;
    logic [31:0] ex;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    logic   ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'({32'd0, x});
    uy  = longint'({32'd0, y});
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f3)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      3'd6: begin
        if (y == 32'd0) return x;
        if (ovf) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 32'd0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    bit fastp;
    fastp = f3[2] && ((y == 32'd0) ||
            (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    return fastp ? 1 : ITER + 1;
  endfunction

  // Issue one operation and follow it to done; hold keeps start asserted throughout.
  task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] av,
                       input logic [31:0] bv, input logic [4:0] rd, input logic [31:0] ex,
                       input int lat, input bit hold);
    int stalls = 0;
    bit got = 0;
    @(posedge clock); #1;
    start = 1'b1; funct3 = f3; a = av; b = bv; rd_in = rd;
    @(negedge clock);
    chk({nm, "_stall_issue"}, 32'(stall), 32'd1);
    for (int i = 1; i <= lat + 4 && !got; i++) begin
      @(posedge clock); #1;
      if (!hold) start = 1'b0;
      @(negedge clock);
      if (done) begin
        got = 1;
        chk({nm, "_latency"}, 32'(i), 32'(lat));
        chk({nm, "_result"}, result, ex);
        chk({nm, "_rd_out"}, 32'(rd_out), 32'(rd));
        chk({nm, "_stall_done"}, 32'(stall), 32'd0);
      end else if (stall) begin
        stalls++;
      end
    end
    if (!got) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
    else      chk({nm, "_stall_cycles"}, 32'(stalls), 32'(lat - 1));
    @(negedge clock);
    chk({nm, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    start = 1'b0;
  endtask

  task automatic expect_no_done(input string nm, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (done) seen++;
    end
    chk({nm, "_no_done"}, 32'(seen), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    reset = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'd0;
    a = 32'd0; b = 32'd0; rd_in = 5'd0;

    tbl[0]  = '{"mul_7x6",     3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         ITER + 1};
    tbl[1]  = '{"mulh_min",    3'd1, 32'h8000_0000,  32'h8000_0000,  5'd1,  32'h4000_0000,  ITER + 1};
    tbl[2]  = '{"mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  ITER + 1};
    tbl[3]  = '{"div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  ITER + 1};
    tbl[4]  = '{"rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  ITER + 1};
    tbl[5]  = '{"divu_100_7",  3'd5, 32'd100,        32'd7,          5'd6,  32'd14,         ITER + 1};
    tbl[6]  = '{"divu_by0",    3'd5, 32'd123,        32'd0,          5'd7,  32'hFFFF_FFFF,  1};
    tbl[7]  = '{"rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          1};
    tbl[8]  = '{"div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1};
    tbl[9]  = '{"remu_by0",    3'd7, 32'd100,        32'd0,          5'd10, 32'd100,        1};
    tbl[10] = '{"mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF,  32'd2,          5'd11, 32'hFFFF_FFFF,  ITER + 1};
    tbl[11] = '{"mul_wrap",    3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 32'd1,          ITER + 1};

    // Outputs held at zero in reset, even with start raised.
    #3 start = 1'b1;
    #4;
    chk("reset_outputs", {stall, busy, done, rd_out, result[24:0]}, 32'd0);
    start = 1'b0;
    @(negedge clock); reset = 1'b1;

    foreach (tbl[i])
      do_op(tbl[i].name, tbl[i].f3, tbl[i].av, tbl[i].bv, tbl[i].rd, tbl[i].ex, tbl[i].lat, 1'b0);

    // start held through RUN and DONE must not re-issue.
    do_op("mul_hold", 3'd0, 32'd1000, 32'd3, 5'd12, 32'd3000, ITER + 1, 1'b1);
    expect_no_done("mul_hold", ITER + 4);

    // Kill a DIV at N+10: idle at N+11, no done, then a normal op.
    @(posedge clock); #1;
    start = 1'b1; funct3 = 3'd4; a = 32'd1000; b = 32'd10; rd_in = 5'd13;
    @(posedge clock); #1 start = 1'b0;
    repeat (9) @(posedge clock);
    #1 kill = 1'b1;
    @(posedge clock); #1 kill = 1'b0;
    @(negedge clock);
    chk("kill_idle", {29'd0, busy, done, stall}, 32'd0);
    expect_no_done("kill", ITER + 4);
    do_op("after_kill", 3'd4, 32'd1000, 32'd10, 5'd14, 32'd100, ITER + 1, 1'b0);

    // Reset mid-MUL at N+5: immediate zeros, aborted op never completes.
    @(posedge clock); #1;
    start = 1'b1; funct3 = 3'd0; a = 32'd9; b = 32'd9; rd_in = 5'd15;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("reset_mid_outputs", {stall, busy, done, rd_out, result[24:0]}, 32'd0);
    chk("reset_mid_result", result, 32'd0);
    @(negedge clock); reset = 1'b1;
    expect_no_done("reset_mid", ITER + 4);
    do_op("after_reset", 3'd0, 32'd123, 32'd456, 5'd16, 32'd56088, ITER + 1, 1'b0);

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] x, y;
      int          sel;
      f3  = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) y = 32'($urandom_range(1, 15));
      else if (sel == 3) x = 32'($urandom_range(0, 255));
      do_op("rand", f3, x, y, 5'($urandom_range(0, 31)), model(f3, x, y), model_lat(f3, x, y), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
